// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive frame controller.
// Holds the FSM state encoding, data-bit limits and the per-frame configuration.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    localparam logic [3:0] MIN_DATA_BITS     = 4'd5;
    localparam logic [3:0] ABS_MAX_DATA_BITS = 4'd9;

    typedef struct packed {
        logic [3:0] data_bits;
        logic       parity_en;
        logic       parity_odd;
        logic       two_stop;
        logic       oversample_x16;
    } cfg_t;

    // Out-of-range requests saturate to the nearest legal data-bit count.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                   input logic [3:0] max_bits);
        logic [3:0] res;
        res = req;
        if (req < MIN_DATA_BITS) res = MIN_DATA_BITS;
        if (req > max_bits)      res = max_bits;
        return res;
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_counter.sv
// Small up-counter with synchronous load; used as the data bit index.
// Load takes priority over increment.
module uart_rx_frame_ctrl_counter
    import uart_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: assembles data/parity/stop bits from the bit
// detector into words and presents them through a one-entry valid/ready buffer.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic                     bit_in_valid,
    output logic                     bit_in_ready,
    output logic                     frame_done,
    output logic                     oversample_x16,
    input  logic [3:0]               cfg_data_bits,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_parity_odd,
    input  logic                     cfg_two_stop,
    input  logic                     cfg_oversample_x16,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     busy
);

    localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

    state_t                   state;
    cfg_t                     cfg_q;
    cfg_t                     cfg_in;
    logic [MAX_DATA_BITS-1:0] shift_q;
    logic [MAX_DATA_BITS-1:0] bit_mask;
    logic [3:0]               bit_idx;
    logic                     par_acc;
    logic                     perr_q;
    logic                     ferr_q;
    logic                     acc;
    logic                     last_data;
    logic                     complete;
    logic                     idx_load;
    logic                     idx_en;

    always_comb begin
        cfg_in                = '0;
        cfg_in.data_bits      = clamp_data_bits(cfg_data_bits, MAX_BITS);
        cfg_in.parity_en      = cfg_parity_en;
        cfg_in.parity_odd     = cfg_parity_odd;
        cfg_in.two_stop       = cfg_two_stop;
        cfg_in.oversample_x16 = cfg_oversample_x16;
    end

    assign acc       = bit_in_valid && bit_in_ready;
    assign last_data = (bit_idx == cfg_q.data_bits - 4'd1);
    assign complete  = acc && ((state == STOP1 && !cfg_q.two_stop) || state == STOP2);
    assign bit_mask  = MAX_DATA_BITS'(bit_in) << bit_idx;
    assign idx_load  = acc && (state == IDLE);
    assign idx_en    = acc && (state == DATA) && !last_data;
    assign busy      = (state != IDLE);

    uart_rx_frame_ctrl_counter #(.W(4)) u_bit_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .load_val (4'd1),
        .en       (idx_en),
        .count    (bit_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cfg_q          <= '0;
            shift_q        <= '0;
            par_acc        <= 1'b0;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            bit_in_ready   <= 1'b0;
            frame_done     <= 1'b0;
            overrun        <= 1'b0;
            oversample_x16 <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            parity_err     <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            bit_in_ready <= 1'b1;
            frame_done   <= complete;
            overrun      <= complete && rx_valid && !rx_ready;

            if (state == IDLE && !acc) oversample_x16 <= cfg_oversample_x16;

            // A finished frame loads if the buffer is empty or draining this cycle.
            if (complete && (!rx_valid || rx_ready)) begin
                rx_data    <= shift_q;
                parity_err <= perr_q;
                frame_err  <= ferr_q | ~bit_in;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (acc) begin
                case (state)
                    IDLE: begin
                        cfg_q   <= cfg_in;
                        shift_q <= MAX_DATA_BITS'(bit_in);
                        par_acc <= bit_in;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                        state   <= DATA;
                    end
                    DATA: begin
                        shift_q <= shift_q | bit_mask;
                        par_acc <= par_acc ^ bit_in;
                        if (last_data) state <= cfg_q.parity_en ? PARITY : STOP1;
                    end
                    PARITY: begin
                        perr_q <= ((par_acc ^ bit_in) != cfg_q.parity_odd);
                        state  <= STOP1;
                    end
                    STOP1: begin
                        if (!bit_in) ferr_q <= 1'b1;
                        state <= cfg_q.two_stop ? STOP2 : IDLE;
                    end
                    STOP2: begin
                        if (!bit_in) ferr_q <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
